// File: rtl/dmem_shadow_responder.sv
// Memory-bus responder with programmable wait states that shadows writes to a
// small set of tracked words and merges the shadowed bytes into read data.
module dmem_shadow_responder #(
  parameter int XLEN     = 32,
  parameter int NTRACK   = 2,
  parameter int MAX_WAIT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [31:0]          mem_addr,
  input  logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN/8-1:0]    mem_wstrb,
  output logic                 mem_ready,
  output logic [XLEN-1:0]      mem_rdata,
  input  logic [XLEN-1:0]      ext_rdata,
  input  logic [3:0]           wait_req,
  input  logic [32*NTRACK-1:0] track_addr,
  input  logic [NTRACK-1:0]    track_en,
  output logic                 proto_err,
  output logic [NTRACK-1:0]    hit
);

  localparam int          NB        = XLEN / 8;
  localparam int          LSB       = (XLEN == 64) ? 3 : 2;
  localparam logic [31:0] WORD_MASK = ~((32'd1 << LSB) - 32'd1);
  localparam logic [3:0]  MAX_W     = 4'(MAX_WAIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NB-1:0]   wstrb_q, wstrb_d;
  logic            instr_q, instr_d;
  logic            proto_q, proto_d;

  logic [NTRACK-1:0][XLEN-1:0] data_q, data_d;
  logic [NTRACK-1:0][NB-1:0]   valid_q, valid_d;

  logic [NTRACK-1:0] match_s;
  logic [3:0]        wait_clip_s;
  logic              in_resp_s;
  logic              wr_commit_s;
  logic              busy_s;
  logic              mismatch_s;

  assign wait_clip_s = (wait_req > MAX_W) ? MAX_W : wait_req;
  assign in_resp_s   = (state_q == S_RESP);
  assign wr_commit_s = in_resp_s && (wstrb_q != '0);
  assign busy_s      = (state_q == S_WAIT) || (state_q == S_RESP);
  assign mismatch_s  = !mem_valid || (mem_addr != addr_q) ||
                       (mem_wdata != wdata_q) || (mem_wstrb != wstrb_q);

  assign mem_ready = in_resp_s;
  assign hit       = in_resp_s ? match_s : '0;
  assign proto_err = proto_q;

  // Word-granular match of the latched request against each tracked entry
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NTRACK; i++) begin
      match_s[i] = track_en[i] && !instr_q &&
                   (((addr_q ^ track_addr[32*i +: 32]) & WORD_MASK) == 32'd0);
    end
  end

  // Request sequencing: accept, count down wait states, pulse ready once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          cnt_d   = wait_clip_s;
          state_d = (wait_clip_s != 4'd0) ? S_WAIT : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky flag for a request that drops or changes while outstanding
  always_comb begin
    proto_d = proto_q | (busy_s & mismatch_s);
  end

  // Byte-wise read-modify-write of every matching shadow entry on a write response
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int i = 0; i < NTRACK; i++) begin
      for (int b = 0; b < NB; b++) begin
        data_d[i][8*b +: 8] = (wr_commit_s && match_s[i] && wstrb_q[b]) ?
                              wdata_q[8*b +: 8] : data_q[i][8*b +: 8];
        valid_d[i][b]       = valid_q[i][b] | (wr_commit_s && match_s[i] && wstrb_q[b]);
      end
    end
  end

  // Read merge: iterate high-to-low so the lowest-index valid entry wins per byte
  always_comb begin
    mem_rdata = ext_rdata;
    for (int i = NTRACK - 1; i >= 0; i--) begin
      for (int b = 0; b < NB; b++) begin
        mem_rdata[8*b +: 8] = (in_resp_s && (wstrb_q == '0) && match_s[i] && valid_q[i][b]) ?
                              data_q[i][8*b +: 8] : mem_rdata[8*b +: 8];
      end
    end
  end

  // State, latched request and shadow storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      proto_q <= 1'b0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      proto_q <= proto_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_dmem_shadow_responder.sv
// Table-driven bench with a response scoreboard for dmem_shadow_responder
// (XLEN=32, NTRACK=2, MAX_WAIT=7).
module tb_dmem_shadow_responder;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ext_rdata;
  logic [3:0]  wait_req;
  logic [63:0] track_addr;
  logic [1:0]  track_en;
  logic        proto_err;
  logic [1:0]  hit;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [3:0]  wreq;
    logic [1:0]  en;
    logic [31:0] ext;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_hit;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  hit;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  vec_t tab[10];

  dmem_shadow_responder #(.XLEN(32), .NTRACK(2), .MAX_WAIT(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ext_rdata  (ext_rdata),
    .wait_req   (wait_req),
    .track_addr (track_addr),
    .track_en   (track_en),
    .proto_err  (proto_err),
    .hit        (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr,
                              input logic [3:0] wreq, input logic [1:0] en,
                              input logic [31:0] ext, input logic [31:0] exp_rdata,
                              input logic [1:0] exp_hit, input int exp_lat);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.instr = instr;
    v.wreq = wreq; v.en = en; v.ext = ext; v.exp_rdata = exp_rdata;
    v.exp_hit = exp_hit; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic do_reset();
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive one request, queue its expectation, and score the response when ready arrives
  task automatic run_vec(input string name, input vec_t v);
    exp_t e;
    bit   seen;
    int   n;
    @(posedge clk);
    #1;
    mem_valid = 1'b1;
    mem_instr = v.instr;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.wstrb;
    wait_req  = v.wreq;
    track_en  = v.en;
    ext_rdata = v.ext;
    e.rdata = v.exp_rdata;
    e.hit   = v.exp_hit;
    e.lat   = v.exp_lat + 1;
    exp_q.push_back(e);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 25) begin
      @(negedge clk);
      if (mem_ready) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        chk({name, "_lat"},   64'(n),         64'(e.lat));
        chk({name, "_rdata"}, 64'(mem_rdata), 64'(e.rdata));
        chk({name, "_hit"},   64'(hit),       64'(e.hit));
      end else begin
        n++;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready expected ready", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk({name, "_no_b2b"},  64'(mem_ready), 64'd0);
    chk({name, "_idlehit"}, 64'(hit),       64'd0);
  endtask

  initial begin
    bit seen;
    int n;
    mem_valid  = 1'b0;
    mem_instr  = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_wstrb  = 4'd0;
    wait_req   = 4'd0;
    ext_rdata  = 32'hCAFEF00D;
    track_en   = 2'b11;
    track_addr = {32'h0000_0200, 32'h0000_0100};
    reset      = 1'b1;
    #1;
    chk("rst_ready", 64'(mem_ready), 64'd0);
    chk("rst_hit",   64'(hit),       64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);
    chk("rst_rdata", 64'(mem_rdata), 64'h0000_0000_CAFE_F00D);
    do_reset();

    // entry 0 at 0x100, entry 1 at 0x200
    tab[0] = mk(32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 4'd0,  2'b11, 32'h11111111, 32'h11111111, 2'b01, 0);
    tab[1] = mk(32'h102, 32'h0,        4'b0000, 1'b0, 4'd0,  2'b11, 32'h22222222, 32'hDEADBEEF, 2'b01, 0);
    tab[2] = mk(32'h200, 32'h000000AA, 4'b0001, 1'b0, 4'd3,  2'b11, 32'h12345678, 32'h12345678, 2'b10, 3);
    tab[3] = mk(32'h200, 32'h0,        4'b0000, 1'b0, 4'd12, 2'b11, 32'h12345678, 32'h123456AA, 2'b10, 7);
    tab[4] = mk(32'h300, 32'h0,        4'b0000, 1'b0, 4'd1,  2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1);
    tab[5] = mk(32'h100, 32'h0,        4'b0000, 1'b1, 4'd0,  2'b11, 32'h33333333, 32'h33333333, 2'b00, 0);
    tab[6] = mk(32'h100, 32'h00CC0000, 4'b0100, 1'b0, 4'd2,  2'b11, 32'h00000000, 32'h00000000, 2'b01, 2);
    tab[7] = mk(32'h101, 32'h0,        4'b0000, 1'b0, 4'd0,  2'b11, 32'h44444444, 32'hDECCBEEF, 2'b01, 0);
    tab[8] = mk(32'h200, 32'h0000BB00, 4'b0010, 1'b0, 4'd15, 2'b01, 32'h01020304, 32'h01020304, 2'b00, 7);
    tab[9] = mk(32'h203, 32'h0,        4'b0000, 1'b0, 4'd0,  2'b11, 32'h12345678, 32'h123456AA, 2'b10, 0);
    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), tab[i]);
    end
    chk("clean_proto", 64'(proto_err), 64'd0);

    // both entries on the same word; entry 0 must win on reads
    track_addr = {32'h0000_0200, 32'h0000_0200};
    do_reset();
    run_vec("dup_wr0", mk(32'h200, 32'h00000055, 4'b0001, 1'b0, 4'd0, 2'b11, 32'h0, 32'h0, 2'b11, 0));
    run_vec("dup_wr1", mk(32'h200, 32'h00000077, 4'b0001, 1'b0, 4'd0, 2'b10, 32'h0, 32'h0, 2'b10, 0));
    run_vec("dup_rd0", mk(32'h200, 32'h0, 4'b0000, 1'b0, 4'd0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFF55, 2'b11, 0));
    run_vec("dup_rd1", mk(32'h200, 32'h0, 4'b0000, 1'b0, 4'd0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFF77, 2'b10, 0));

    // reset landing in RESP of a write
    @(posedge clk);
    #1;
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h200; mem_wdata = 32'h00000099;
    mem_wstrb = 4'b0001; wait_req = 4'd0; track_en = 2'b11; ext_rdata = 32'h0;
    @(negedge clk);
    chk("rr_accept_ready", 64'(mem_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rr_in_resp", 64'(mem_ready), 64'd1);
    reset = 1'b1;
    mem_valid = 1'b0;
    #1;
    chk("rr_ready_drop", 64'(mem_ready), 64'd0);
    chk("rr_hit_drop",   64'(hit),       64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_vec("rr_read", mk(32'h200, 32'h0, 4'b0000, 1'b0, 4'd0, 2'b11, 32'hABCDEF01, 32'hABCDEF01, 2'b11, 0));

    // address changed mid-WAIT
    @(posedge clk);
    #1;
    mem_valid = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h0; mem_wstrb = 4'd0;
    wait_req = 4'd3; ext_rdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1 mem_addr = 32'h304;
    @(negedge clk);
    chk("pe_before", 64'(proto_err), 64'd0);
    @(posedge clk);
    #1 mem_addr = 32'h300;
    @(negedge clk);
    chk("pe_set", 64'(proto_err), 64'd1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
      else n++;
    end
    chk("pe_completes", 64'(seen), 64'd1);
    @(posedge clk);
    #1 mem_valid = 1'b0;
    run_vec("pe_clean", mk(32'h300, 32'h0, 4'b0000, 1'b0, 4'd1, 2'b11, 32'h0BADF00D, 32'h0BADF00D, 2'b00, 1));
    chk("pe_sticky", 64'(proto_err), 64'd1);
    do_reset();
    #1;
    chk("pe_cleared", 64'(proto_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_shadow_responder.md
DMEM_SHADOW_RESPONDER -- requirements
Module: dmem_shadow_responder

Interface
REQ-001 Parameter XLEN, default 32, bus data width in bits; legal values 32 and 64.
REQ-002 Parameter NTRACK, default 2, number of tracked shadow words; legal range 1..8.
REQ-003 Parameter MAX_WAIT, default 7, maximum inserted wait states per transaction; legal range 0..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_valid  input  1  core request valid.
REQ-007 mem_instr  input  1  request is an instruction fetch; never updates shadow state.
REQ-008 mem_addr  input  32  byte address of the request.
REQ-009 mem_wdata  input  XLEN  write data.
REQ-010 mem_wstrb  input  XLEN/8  byte write strobes; all zero means read.
REQ-011 mem_ready  output  1  registered completion pulse.
REQ-012 mem_rdata  output  XLEN  read data, valid while mem_ready is high.
REQ-013 ext_rdata  input  XLEN  free environment data for untracked addresses and unwritten bytes.
REQ-014 wait_req  input  4  requested wait states, sampled at request acceptance.
REQ-015 track_addr  input  32*NTRACK  tracked byte addresses, entry i at bits [32*i+31:32*i]; held stable after reset.
REQ-016 track_en  input  NTRACK  per-entry enable.
REQ-017 proto_err  output  1  sticky handshake-violation flag.
REQ-018 hit  output  NTRACK  per-entry match for the transaction completing this cycle.

Function
REQ-019 Word match SHALL compare mem_addr and track_addr above bit log2(XLEN/8); low address bits SHALL be ignored.
REQ-020 Entry i SHALL match only when track_en[i] is high and mem_instr is low.
REQ-021 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-022 IDLE with mem_valid high SHALL latch cnt = min(wait_req, MAX_WAIT) and addr/wdata/wstrb/instr, then go to WAIT if cnt>0, else RESP.
REQ-023 WAIT SHALL decrement cnt each cycle and go to RESP when cnt reaches 1 in the current cycle.
REQ-024 Latency SHALL be exact: request accepted at cycle T, mem_ready high in cycle T+1+cnt only.
REQ-025 RESP SHALL drive mem_ready high for exactly one cycle, then return to IDLE.
REQ-026 In RESP, a write SHALL update the strobed bytes of every matching entry and set those bytes' valid bits, committed at the RESP clock edge.
REQ-027 In RESP, each mem_rdata byte SHALL come from the lowest-index matching entry whose valid bit for that byte is set; otherwise it SHALL come from ext_rdata.
REQ-028 Outside RESP, mem_rdata SHALL equal ext_rdata.
REQ-029 mem_rdata SHALL equal ext_rdata on writes; writes SHALL not alter ext_rdata passthrough.
REQ-030 In RESP, hit SHALL show the per-entry match; outside RESP it SHALL be 0.
REQ-031 proto_err SHALL set if, in WAIT or RESP, mem_valid is low or mem_addr/mem_wdata/mem_wstrb differ from the latched values.
REQ-032 Once set, proto_err SHALL stay set until reset.
REQ-033 mem_valid high in the cycle after RESP SHALL be accepted as a new request; there SHALL be no back-to-back ready pulses.
REQ-034 Tracked data SHALL be read-modify-write at byte granularity: a partial write SHALL leave unstrobed bytes and their valid bits unchanged.

Reset
REQ-035 On reset assertion, the block SHALL immediately enter IDLE and force mem_ready=0, hit=0 and proto_err=0.
REQ-036 On reset assertion, all shadow data SHALL be cleared to 0 and all valid bits cleared.
REQ-037 Reset during WAIT or RESP SHALL abort the transaction with no shadow write committed.
REQ-038 After reset deassertion, the first request SHALL be accepted in the first IDLE cycle in which mem_valid is high.

Verification
REQ-039 Write 0xDEADBEEF with wstrb=1111 and wait_req=0 to 0x100, with track_addr[0]=0x100 -> mem_ready at T+1; a subsequent read of 0x102 returns 0xDEADBEEF with hit=01.
REQ-040 Write 0x000000AA with wstrb=0001 to a fresh tracked word, then read with ext_rdata=0x12345678 -> mem_rdata=0x123456AA.
REQ-041 Set wait_req=12 with MAX_WAIT=7 -> mem_ready only at T+8; wait_req=3 -> mem_ready only at T+4.
REQ-042 Set both entries to 0x200 and write 0x55 to byte 0 -> both entries updated and hit=11; a later read returns entry 0's data.
REQ-043 Change mem_addr while in WAIT -> proto_err=1 from the next cycle, held through later clean transactions until reset.
REQ-044 Assert reset in RESP of a write -> mem_ready drops immediately; a subsequent read returns ext_rdata with all valid bits clear.
